reg_chain_word_packer: RTL and testbench
========================================

Name: reg_chain_word_packer

Overview:
- Downstream consumer of the two-stage extracted-register example.
- Takes the free-running 8-bit registered output, one sample per enabled cycle, and packs WORDS consecutive samples into one wide word.
- Emits packed words on a valid/ready handshake stream through a 2-entry output FIFO.
- Counts words lost to back-pressure.

Parameters:
- DATA_WIDTH, 8, width of one input sample.
- WORDS, 4, samples per output word (>=2).
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  DATA_WIDTH  sample from upstream register stage.
- din_en  in  1  sample din this cycle.
- dout_data  out  DATA_WIDTH*WORDS  packed word at FIFO head.
- dout_vld  out  1  dout_data valid.
- dout_rd  in  1  consumer ready; transfer when dout_vld && dout_rd.
- drop_cnt  out  DROP_CNT_WIDTH  number of completed words dropped (saturating).
- busy  out  1  partial word in progress (idx != 0).

Behaviour:
- Clock and reset:
  - One clock (clk); reset rst is synchronous and active-high.
  - rst=1 at a rising edge forces: idx=0, pack register=0, FIFO empty, drop_cnt=0.
  - Resulting outputs: dout_vld=0, dout_data=0, busy=0.
  - rst has priority over every other event that cycle.
- Packing:
  - idx counts 0..WORDS-1.
  - On din_en=1, din is stored to lane idx, bits [DATA_WIDTH*idx +: DATA_WIDTH]. The first sample lands in the LSBs (little-endian).
  - If idx<WORDS-1, idx increments.
  - If idx==WORDS-1, the completed word is formed from the stored lanes plus the current din, and is offered to the FIFO. idx wraps to 0 regardless of acceptance.
  - din_en=0: no state change in the packer.
- FIFO push rule:
  - The push succeeds if FIFO count<2, or if count==2 and a pop occurs the same cycle (dout_vld && dout_rd).
  - Otherwise the word is dropped and drop_cnt increments. drop_cnt saturates at all-ones.
- FIFO pop: on dout_vld && dout_rd the head is removed and the next entry becomes the head in the following cycle.
- Outputs:
  - dout_vld = (count != 0); all outputs are registered.
  - dout_data equals the head entry when dout_vld=1. When dout_vld=0 it is undefined and must not be checked.
  - dout_data must stay stable while dout_vld && !dout_rd.
- Latency:
  - A word completed at edge N (last sample accepted) appears with dout_vld=1 after edge N, in the cycle following the completing sample.
  - With dout_rd held at 1, sustained throughput is one word per WORDS enabled samples, with no drops.
- Simultaneous push and pop:
  - Count is unchanged.
  - Ordering is preserved: the popped word is always older than the pushed word.
- Empty FIFO with a push: the word bypasses nothing and is registered; there is no combinational din-to-dout path.
- Reset mid-packet: partial lanes are discarded; the next sample starts at lane 0.
- busy = (idx != 0), registered.

Decomposition:
- Package reg_chain_pkg holds:
  - constants DATA_WIDTH=8, WORDS=4, FIFO_DEPTH=2;
  - derived widths IDX_WIDTH=clog2(WORDS) and WORD_WIDTH=DATA_WIDTH*WORDS.
- Sub-module handshaked_fifo2 provides the 2-entry FIFO:
  - ports clk, rst, push, push_data, full, pop, head_data, vld;
  - it must allow push when full combined with a pop in the same cycle.
- The packer, idx counter, drop counter and busy logic live in the top module.

Test Plan:
- Basic packing: reset, then din_en=1 with din=0x11,0x22,0x33,0x44 on consecutive cycles and dout_rd=1 -> one cycle after 0x44, dout_vld=1, dout_data=0x44332211; drop_cnt=0.
- Gaps: same four bytes with din_en=0 cycles interleaved (pattern 1,0,0,1,1,0,1) -> single word 0x44332211; busy=1 from after the first sample until the word completes.
- Back-pressure and drop: dout_rd=0, feed 12 samples 0x00..0x0B -> FIFO holds 0x03020100 then 0x07060504; the third word is dropped and drop_cnt=1; dout_data is stable at 0x03020100.
- Full with same-cycle pop: FIFO full, dout_rd=1 exactly on the cycle the 4th sample of the next word arrives -> no drop (drop_cnt unchanged), count stays 2, pop order is oldest first.
- Reset mid-packet: feed 0xAA,0xBB, assert rst for 1 cycle, then feed 0x01,0x02,0x03,0x04 -> only 0x04030201 emitted; drop_cnt=0; busy=0 right after reset.
- Saturation: DROP_CNT_WIDTH=2, dout_rd=0, force 5 drops -> drop_cnt=3 and holds at 3.

Source files
------------

// File: rtl/reg_chain_pkg.sv
// ---------------------------------------------------------------------------
// reg_chain_pkg
//   Shared constants for the register-chain word packer slice.
//
//   DATA_WIDTH     : width of one upstream sample
//   WORDS          : samples packed into one output word
//   FIFO_DEPTH     : entries in the output FIFO
//   DROP_CNT_WIDTH : default width of the saturating drop counter
//   IDX_WIDTH      : width of the lane index counter
//   WORD_WIDTH     : width of one packed output word
// ---------------------------------------------------------------------------
package reg_chain_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int WORDS          = 4;
  localparam int FIFO_DEPTH     = 2;
  localparam int DROP_CNT_WIDTH = 16;

  localparam int IDX_WIDTH  = $clog2(WORDS);
  localparam int WORD_WIDTH = DATA_WIDTH * WORDS;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/handshaked_fifo2.sv
// ---------------------------------------------------------------------------
// handshaked_fifo2
//   Two-entry FIFO with registered head and valid. A push arriving while the
//   FIFO is full is still accepted when the head is popped in the same cycle.
//
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   push      in   request to write push_data
//   push_data in   word to write
//   full      out  both entries occupied
//   pop       in   consumer ready; removes head when vld is high
//   head_data out  oldest entry (registered)
//   vld       out  FIFO holds at least one entry (registered)
// ---------------------------------------------------------------------------
module handshaked_fifo2 #(
  parameter int WIDTH = reg_chain_pkg::WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             vld
);

  import reg_chain_pkg::*;

  logic [1:0]       count;
  logic [1:0]       count_next;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [WIDTH-1:0] slot0_next;
  logic [WIDTH-1:0] slot1_next;
  logic             vld_q;
  logic             pop_fire;
  logic             push_fire;

  assign full      = (count == 2'(FIFO_DEPTH));
  assign pop_fire  = pop && vld_q;
  // A full FIFO can take a new word only because the head leaves this cycle.
  assign push_fire = push && (!full || pop_fire);

  assign head_data = slot0;
  assign vld       = vld_q;

  // Next-state for the two slots. slot0 is always the head; on a pop the
  // second entry shifts forward, so ordering is oldest-first by construction.
  always_comb begin
    count_next = count;
    slot0_next = slot0;
    slot1_next = slot1;
    unique case ({push_fire, pop_fire})
      2'b10: begin
        if (count == 2'd0) begin
          slot0_next = push_data;
        end else begin
          slot1_next = push_data;
        end
        count_next = count + 2'd1;
      end
      2'b01: begin
        slot0_next = slot1;
        count_next = count - 2'd1;
      end
      2'b11: begin
        // Count stays the same; the popped word is older than the pushed one.
        if (count == 2'd1) begin
          slot0_next = push_data;
        end else begin
          slot0_next = slot1;
          slot1_next = push_data;
        end
      end
      default: begin
      end
    endcase
  end

  // Storage plus a registered valid flag derived from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
      vld_q <= 1'b0;
    end else begin
      count <= count_next;
      slot0 <= slot0_next;
      slot1 <= slot1_next;
      vld_q <= (count_next != 2'd0);
    end
  end

endmodule

// File: rtl/reg_chain_word_packer.sv
// ---------------------------------------------------------------------------
// reg_chain_word_packer
//   Packs WORDS consecutive enabled samples (first sample in the LSBs) into
//   one wide word and offers it to a two-entry handshaked output FIFO. Words
//   that find the FIFO full with no same-cycle pop are dropped and counted
//   in a saturating counter.
//
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high; priority over all else
//   din       in   sample from the upstream register stage
//   din_en    in   capture din this cycle
//   dout_data out  packed word at the FIFO head
//   dout_vld  out  dout_data valid
//   dout_rd   in   consumer ready; transfer when dout_vld && dout_rd
//   drop_cnt  out  completed words dropped (saturating at all-ones)
//   busy      out  partial word in progress (registered idx != 0)
// ---------------------------------------------------------------------------
module reg_chain_word_packer #(
  parameter int DATA_WIDTH     = reg_chain_pkg::DATA_WIDTH,
  parameter int WORDS          = reg_chain_pkg::WORDS,
  parameter int DROP_CNT_WIDTH = reg_chain_pkg::DROP_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        din_en,
  output logic [DATA_WIDTH*WORDS-1:0] dout_data,
  output logic                        dout_vld,
  input  logic                        dout_rd,
  output logic [DROP_CNT_WIDTH-1:0]   drop_cnt,
  output logic                        busy
);

  import reg_chain_pkg::*;

  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WORD_W = DATA_WIDTH * WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          idx_next;
  logic [WORD_W-1:0]         pack;
  logic [WORD_W-1:0]         word_done;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic                      busy_q;
  logic                      last_sample;
  logic                      fifo_full;
  logic                      pop_fire;
  logic                      drop;

  // The completing sample goes straight into the top lane of the offered
  // word, so the FIFO sees the whole word on the same edge it is completed.
  assign last_sample = din_en && (idx == LAST_IDX);
  assign word_done   = {din, pack[WORD_W-DATA_WIDTH-1:0]};
  assign pop_fire    = dout_vld && dout_rd;
  assign drop        = last_sample && fifo_full && !pop_fire;

  // Lane index advances per enabled sample and wraps after the last lane
  // whether or not the FIFO accepted the word.
  always_comb begin
    idx_next = idx;
    if (din_en) begin
      if (idx == LAST_IDX) begin
        idx_next = '0;
      end else begin
        idx_next = idx + 1'b1;
      end
    end
  end

  // Packer lanes, index, busy flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      pack   <= '0;
      busy_q <= 1'b0;
      drop_q <= '0;
    end else begin
      if (din_en) begin
        pack[idx*DATA_WIDTH +: DATA_WIDTH] <= din;
      end
      idx    <= idx_next;
      busy_q <= (idx_next != '0);
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  handshaked_fifo2 #(
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (last_sample),
    .push_data(word_done),
    .full     (fifo_full),
    .pop      (dout_rd),
    .head_data(dout_data),
    .vld      (dout_vld)
  );

  assign drop_cnt = drop_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_chain_word_packer.sv
module tb_reg_chain_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_en;
  logic        dout_rd;
  logic [31:0] dout_data;
  logic        dout_vld;
  logic [15:0] drop_cnt;
  logic        busy;

  logic [31:0] sat_data;
  logic        sat_vld;
  logic        sat_rd;
  logic [1:0]  sat_drop;
  logic        sat_busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          m_idx;
  logic [31:0] m_word;
  int          exp_drop;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  reg_chain_word_packer u_dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_en   (din_en),
    .dout_data(dout_data),
    .dout_vld (dout_vld),
    .dout_rd  (dout_rd),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  reg_chain_word_packer #(
    .DROP_CNT_WIDTH(2)
  ) u_sat (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_en   (din_en),
    .dout_data(sat_data),
    .dout_vld (sat_vld),
    .dout_rd  (sat_rd),
    .drop_cnt (sat_drop),
    .busy     (sat_busy)
  );

  // Scoreboard monitor: valid must track the expected queue, and every
  // transfer must deliver the oldest expected word.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if (dout_vld !== (exp_q.size() != 0)) begin
        errors++;
        $display("[TB] FAIL sb_vld: dout_vld=%b expected %b", dout_vld, (exp_q.size() != 0));
      end
      if ((exp_q.size() != 0) && dout_rd) begin
        checks++;
        if (dout_data !== exp_q[0]) begin
          errors++;
          $display("[TB] FAIL sb_data: dout_data=%h expected %h", dout_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle; the expected word is queued (or counted as dropped)
  // after the monitor has retired any pop for this cycle.
  task automatic feed(input logic en, input logic [7:0] d, input logic rd);
    din     = d;
    din_en  = en;
    dout_rd = rd;
    @(negedge clk);
    #1;
    if (en) begin
      m_word[m_idx*8 +: 8] = d;
      if (m_idx == 3) begin
        if (exp_q.size() < 2) exp_q.push_back(m_word);
        else exp_drop++;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst     = 1'b1;
    din_en  = 1'b0;
    din     = 8'h00;
    dout_rd = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_idx    = 0;
    m_word   = '0;
    exp_drop = 0;
  endtask

  task automatic test_reset();
    // Enabled samples during reset must be ignored.
    rst     = 1'b1;
    din_en  = 1'b1;
    din     = 8'hFF;
    dout_rd = 1'b1;
    sat_rd  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %b want 0", dout_vld); end
    checks++; if (dout_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 00000000", dout_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++; if (sat_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat_vld: got %b want 0", sat_vld); end
    din_en = 1'b0;
    din    = 8'h00;
    rst    = 1'b0;
    exp_q.delete();
    m_idx    = 0;
    m_word   = '0;
    exp_drop = 0;
    mon_en   = 1'b1;
  endtask

  task automatic test_basic();
    do_reset(1);
    feed(1'b1, 8'h11, 1'b1);
    feed(1'b1, 8'h22, 1'b1);
    feed(1'b1, 8'h33, 1'b1);
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_vld: got %b want 0", dout_vld); end
    feed(1'b1, 8'h44, 1'b1);
    checks++; if (dout_vld !== 1'b1) begin errors++; $display("[TB] FAIL basic_vld: got %b want 1", dout_vld); end
    checks++; if (dout_data !== 32'h44332211) begin errors++; $display("[TB] FAIL basic_data: got %h want 44332211", dout_data); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL basic_drop: got %0d want 0", drop_cnt); end
    feed(1'b0, 8'h00, 1'b1);
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained: got %b want 0", dout_vld); end
  endtask

  task automatic test_gaps();
    logic       en_pat[7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] d_pat[7]    = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h33, 8'h00, 8'h44};
    logic       busy_pat[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      feed(en_pat[i], d_pat[i], 1'b1);
      checks++;
      if (busy !== busy_pat[i]) begin
        errors++;
        $display("[TB] FAIL gaps_busy step %0d: got %b want %b", i, busy, busy_pat[i]);
      end
    end
    checks++; if (dout_data !== 32'h44332211 || dout_vld !== 1'b1) begin errors++; $display("[TB] FAIL gaps_word: vld=%b data=%h want 1/44332211", dout_vld, dout_data); end
    feed(1'b0, 8'h00, 1'b1);
    feed(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_back_pressure();
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      feed(1'b1, 8'(i), 1'b0);
      if (i >= 3) begin
        checks++;
        if (dout_vld !== 1'b1 || dout_data !== 32'h03020100) begin
          errors++;
          $display("[TB] FAIL bp_stable step %0d: vld=%b data=%h want 1/03020100", i, dout_vld, dout_data);
        end
      end
    end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL bp_drop: got %0d want 1", drop_cnt); end
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("[TB] FAIL bp_drop_model: got %0d want %0d", drop_cnt, exp_drop); end
    feed(1'b0, 8'h00, 1'b1);
    checks++; if (dout_data !== 32'h07060504) begin errors++; $display("[TB] FAIL bp_second: got %h want 07060504", dout_data); end
    feed(1'b0, 8'h00, 1'b1);
    feed(1'b0, 8'h00, 1'b1);
    checks++; if (dout_vld !== 1'b0 || drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL bp_after: vld=%b drop=%0d want 0/1", dout_vld, drop_cnt); end
  endtask

  task automatic test_full_pop();
    do_reset(1);
    for (int i = 0; i < 11; i++) feed(1'b1, 8'(8'h10 + i), 1'b0);
    // Full FIFO: the consumer takes the head on the same edge the next word completes.
    feed(1'b1, 8'h1B, 1'b1);
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL fullpop_drop: got %0d want 0", drop_cnt); end
    checks++; if (dout_vld !== 1'b1 || dout_data !== 32'h17161514) begin errors++; $display("[TB] FAIL fullpop_head: vld=%b data=%h want 1/17161514", dout_vld, dout_data); end
    feed(1'b0, 8'h00, 1'b1);
    checks++; if (dout_vld !== 1'b1 || dout_data !== 32'h1B1A1918) begin errors++; $display("[TB] FAIL fullpop_next: vld=%b data=%h want 1/1b1a1918", dout_vld, dout_data); end
    feed(1'b0, 8'h00, 1'b1);
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_empty: got %b want 0", dout_vld); end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    feed(1'b1, 8'hAA, 1'b1);
    feed(1'b1, 8'hBB, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b want 1", busy); end
    do_reset(1);
    checks++; if (busy !== 1'b0 || dout_vld !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_after_reset: busy=%b vld=%b drop=%0d want 0/0/0", busy, dout_vld, drop_cnt); end
    for (int i = 1; i <= 4; i++) feed(1'b1, 8'(i), 1'b1);
    checks++; if (dout_vld !== 1'b1 || dout_data !== 32'h04030201) begin errors++; $display("[TB] FAIL mid_word: vld=%b data=%h want 1/04030201", dout_vld, dout_data); end
    feed(1'b0, 8'h00, 1'b1);
    feed(1'b0, 8'h00, 1'b1);
    checks++; if (dout_vld !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_end: vld=%b drop=%0d want 0/0", dout_vld, drop_cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] sat_exp[7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset(1);
    sat_rd = 1'b0;
    for (int w = 0; w < 7; w++) begin
      for (int b = 0; b < 4; b++) feed(1'b1, 8'(w*16 + b), 1'b1);
      checks++;
      if (sat_drop !== sat_exp[w]) begin
        errors++;
        $display("[TB] FAIL sat_drop word %0d: got %0d want %0d", w, sat_drop, sat_exp[w]);
      end
    end
    checks++; if (sat_vld !== 1'b1 || sat_data !== 32'h03020100) begin errors++; $display("[TB] FAIL sat_head: vld=%b data=%h want 1/03020100", sat_vld, sat_data); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL sat_main_drop: got %0d want 0", drop_cnt); end
    feed(1'b0, 8'h00, 1'b1);
    feed(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    din     = 8'h00;
    din_en  = 1'b0;
    dout_rd = 1'b0;
    sat_rd  = 1'b0;
    m_idx   = 0;
    m_word  = '0;
    exp_drop = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_back_pressure();
    test_full_pop();
    test_reset_mid();
    test_saturation();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
